// File: rtl/axilite_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite master.
package axilite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R
    } axilite_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] TIMEOUT_RESP = RESP_SLVERR;

endpackage

// File: rtl/axilite_timeout_cnt.sv
// Per-phase wait counter; expire_o is high during the last allowed cycle of a phase.
module axilite_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axilite_master_fsm.sv
// Single-outstanding AXI4-Lite master: one local request -> one AXI-Lite write or read, with per-phase timeout.
// Optional AXI_PROT_EN adds constant m_axi_awprot/m_axi_arprot outputs.
module axilite_master_fsm
    import axilite_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                m_axi_aclk,
    input  logic                m_axi_areset,
    input  logic                new_tx,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic [1:0]          resp,
    output logic                wr_timeout,
    output logic                rd_timeout,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
`ifdef AXI_PROT_EN
    output logic [2:0]          m_axi_awprot,
    output logic [2:0]          m_axi_arprot,
`endif
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp
);
    localparam int STRB_W = DATA_W / 8;

    axilite_state_e    state_q, state_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        resp_q, resp_d;
    logic              wr_to_q, wr_to_d, rd_to_q, rd_to_d;
    logic              expire, cnt_clear;

    // A channel counts as done once its valid has dropped or is handshaking now.
    logic aw_done, w_done, b_hs, ar_hs, r_hs;
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;
    assign b_hs    = bready_q && m_axi_bvalid;
    assign ar_hs   = arvalid_q && m_axi_arready;
    assign r_hs    = rready_q && m_axi_rvalid;

    assign cnt_clear = (state_q == IDLE) || (state_d != state_q);

    axilite_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout_cnt (
        .clk_i    (m_axi_aclk),
        .rst_i    (m_axi_areset),
        .clear_i  (cnt_clear),
        .enable_i (state_q != IDLE),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        dout_d    = dout_q;
        resp_d    = resp_q;
        wr_to_d   = 1'b0;
        rd_to_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (new_tx) begin
                    if (wr) begin
                        awaddr_d  = waddr;
                        wdata_d   = din;
                        wstrb_d   = '1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        araddr_d  = raddr;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W, WR_B: begin
                if (b_hs) begin
                    resp_d    = m_axi_bresp;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    state_d   = IDLE;
                end else if (state_q == WR_AW_W && aw_done && w_done) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    state_d   = WR_B;
                end else if (expire) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    resp_d    = TIMEOUT_RESP;
                    wr_to_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                    if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                end
            end
            RD_AR, RD_R: begin
                // R may arrive in the same cycle as the AR handshake.
                if (r_hs) begin
                    dout_d    = m_axi_rdata;
                    resp_d    = m_axi_rresp;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    state_d   = IDLE;
                end else if (state_q == RD_AR && ar_hs) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_R;
                end else if (expire) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    resp_d    = TIMEOUT_RESP;
                    rd_to_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            dout_q    <= '0;
            resp_q    <= RESP_OKAY;
            wr_to_q   <= 1'b0;
            rd_to_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            dout_q    <= dout_d;
            resp_q    <= resp_d;
            wr_to_q   <= wr_to_d;
            rd_to_q   <= rd_to_d;
        end
    end

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_rready  = rready_q;
    assign dout          = dout_q;
    assign resp          = resp_q;
    assign wr_timeout    = wr_to_q;
    assign rd_timeout    = rd_to_q;
`ifdef AXI_PROT_EN
    // Unprivileged, secure, data access.
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
`endif

endmodule

// File: tb/tb_axilite_master_fsm.sv
// Self-checking bench for axilite_master_fsm: directed table, hand sequences and randomized transactions.
module tb_axilite_master_fsm;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_tx, wr;
    logic [31:0] waddr, raddr, din, dout;
    logic [1:0]  resp;
    logic        wr_timeout, rd_timeout;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
`ifdef AXI_PROT_EN
    logic [2:0]  awprot, arprot;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] m_dout;

    always #5 clk = ~clk;

    axilite_master_fsm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst), .new_tx(new_tx), .wr(wr),
        .waddr(waddr), .raddr(raddr), .din(din), .dout(dout), .resp(resp),
        .wr_timeout(wr_timeout), .rd_timeout(rd_timeout),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
`ifdef AXI_PROT_EN
        .m_axi_awprot(awprot), .m_axi_arprot(arprot),
`endif
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit any_out();
        return |{awvalid, wvalid, bready, arvalid, rready, awaddr, wdata, wstrb,
                 araddr, dout, resp, wr_timeout, rd_timeout};
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Reference rules: a phase may wait at most TO cycles; completion in the last cycle still counts.
    // Write: AW/W phase lasts max(d1,d2)+1, B phase d3+1. Read: AR at d1, R d2 cycles later.
    function automatic bit exp_timeout(bit is_wr, int d1, int d2, int d3);
        if (is_wr) return (imax(d1, d2) > TO - 1) || (d3 > TO - 1);
        return (d1 > TO - 1) || (d2 > TO);
    endfunction

    function automatic int exp_len(bit is_wr, int d1, int d2, int d3);
        if (is_wr) begin
            if (imax(d1, d2) > TO - 1) return TO;
            if (d3 > TO - 1) return imax(d1, d2) + 1 + TO;
            return imax(d1, d2) + d3 + 2;
        end
        if (d1 > TO - 1) return TO;
        if (d2 > TO) return d1 + 1 + TO;
        return d1 + d2 + 1;
    endfunction

    task automatic clear_slave();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    endtask

    // Issues one request and plays a slave with the given delays; returns what the master reported.
    task automatic do_tx(input bit is_wr, input logic [31:0] a, input logic [31:0] d, input int hold,
                         input int d1, input int d2, input int d3, input logic [1:0] rsp,
                         input logic [31:0] rdat, output bit o_wto, output bit o_rto,
                         output logic [1:0] o_resp, output logic [31:0] o_dout, output int o_len);
        int c, aw_at, w_at, ar_at, pe;
        aw_at = -1; w_at = -1; ar_at = -1; c = 0;
        new_tx = 1; wr = is_wr; din = d;
        waddr = is_wr ? a : ~a;
        raddr = is_wr ? ~a : a;
        @(posedge clk); #1;
        while (c < 4 * TO + 20) begin
            if (c >= hold - 1) new_tx = 0;
            if (!(awvalid || wvalid || bready || arvalid || rready)) break;
            if (is_wr) begin
                pe = imax(d1, d2) < TO - 1 ? imax(d1, d2) : TO - 1;
                if (c <= pe) begin
                    chk("awvalid_cycle", awvalid, c <= d1);
                    chk("wvalid_cycle", wvalid, c <= d2);
                end
                awready = awvalid && (c >= d1);
                wready  = wvalid && (c >= d2);
                if (awvalid && awready) begin aw_at = c; chk("aw_addr", awaddr, a); end
                if (wvalid && wready) begin
                    w_at = c;
                    chk("w_data", wdata, d);
                    chk("w_strb", wstrb, 4'hF);
                end
                bvalid = (aw_at >= 0) && (w_at >= 0) && (c >= imax(aw_at, w_at) + 1 + d3);
                bresp  = rsp;
            end else begin
                if (c <= ((d1 < TO - 1) ? d1 : TO - 1)) chk("arvalid_cycle", arvalid, 1);
                arready = arvalid && (c >= d1);
                if (arvalid && arready) begin ar_at = c; chk("ar_addr", araddr, a); end
                rvalid = (ar_at >= 0) && (c >= ar_at + d2);
                rdata  = rvalid ? rdat : ~rdat;
                rresp  = rsp;
            end
            @(posedge clk); #1;
            c++;
        end
        new_tx = 0;
        clear_slave();
        if (c >= 4 * TO + 20) chk("tx_cycle_budget", c, 0);
        o_wto = wr_timeout; o_rto = rd_timeout; o_resp = resp; o_dout = dout; o_len = c;
        if (is_wr) begin
            chk("awaddr_hold", awaddr, a);
            chk("wdata_hold", wdata, d);
        end else begin
            chk("araddr_hold", araddr, a);
        end
        if (o_wto || o_rto) begin
            @(posedge clk); #1;
            chk("timeout_pulse_1cyc", {wr_timeout, rd_timeout}, 2'b00);
        end
    endtask

    task automatic run_model(input string tag, input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                             input int d1, input int d2, input int d3, input logic [1:0] rsp,
                             input logic [31:0] rdat);
        bit to, owt, ort;
        logic [1:0] oresp;
        logic [31:0] odout;
        int olen;
        to = exp_timeout(is_wr, d1, d2, d3);
        if (!to && !is_wr) m_dout = rdat;
        do_tx(is_wr, a, d, 1, d1, d2, d3, rsp, rdat, owt, ort, oresp, odout, olen);
        chk({tag, "_wr_timeout"}, owt, is_wr && to);
        chk({tag, "_rd_timeout"}, ort, !is_wr && to);
        chk({tag, "_resp"}, oresp, to ? 2'b10 : rsp);
        chk({tag, "_dout"}, odout, m_dout);
        chk({tag, "_len"}, olen, exp_len(is_wr, d1, d2, d3));
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] a, d;
        int          hold, d1, d2, d3;
        logic [1:0]  rsp;
        logic [31:0] rdat;
        bit          ewto, erto;
        logic [1:0]  eresp;
        logic [31:0] edout;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit owt, ort;
        logic [1:0] oresp;
        logic [31:0] odout;
        int olen;

        tbl[0]  = '{1, 32'd3,  32'd3,  7, 7,   7,  0,  2'b00, 32'h0,        0, 0, 2'b00, 32'h0};
        tbl[1]  = '{0, 32'd4,  32'd0,  1, 0,   0,  0,  2'b00, 32'h5,        0, 0, 2'b00, 32'h5};
        tbl[2]  = '{1, 32'd8,  32'hC,  1, 3,   1,  2,  2'b01, 32'h0,        0, 0, 2'b01, 32'h5};
        tbl[3]  = '{1, 32'd9,  32'd9,  1, 100, 0,  0,  2'b00, 32'h0,        1, 0, 2'b10, 32'h5};
        tbl[4]  = '{0, 32'd10, 32'd0,  1, 100, 0,  0,  2'b00, 32'h77,       0, 1, 2'b10, 32'h5};
        tbl[5]  = '{0, 32'd11, 32'd0,  1, 2,   3,  0,  2'b11, 32'hA5,       0, 0, 2'b11, 32'hA5};
        tbl[6]  = '{1, 32'd12, 32'd12, 1, 0,   0,  16, 2'b00, 32'h0,        1, 0, 2'b10, 32'hA5};
        tbl[7]  = '{1, 32'd13, 32'd13, 1, 15,  15, 15, 2'b00, 32'h0,        0, 0, 2'b00, 32'hA5};
        tbl[8]  = '{0, 32'd14, 32'd0,  1, 15,  16, 0,  2'b10, 32'h1234,     0, 0, 2'b10, 32'h1234};
        tbl[9]  = '{0, 32'd15, 32'd0,  1, 0,   17, 0,  2'b00, 32'h9999,     0, 1, 2'b10, 32'h1234};
        tbl[10] = '{1, 32'd16, 32'd16, 1, 16,  0,  0,  2'b00, 32'h0,        1, 0, 2'b10, 32'h1234};
        tbl[11] = '{0, 32'd17, 32'd0,  1, 0,   1,  0,  2'b00, 32'hDEADBEEF, 0, 0, 2'b00, 32'hDEADBEEF};

        rst = 1; new_tx = 0; wr = 0; waddr = 0; raddr = 0; din = 0;
        clear_slave();
        #1;
        chk("reset_outputs_zero", any_out(), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_dout = 0;
        chk("idle_after_reset", any_out(), 0);

        for (int i = 0; i < 12; i++) begin
            do_tx(tbl[i].is_wr, tbl[i].a, tbl[i].d, tbl[i].hold, tbl[i].d1, tbl[i].d2, tbl[i].d3,
                  tbl[i].rsp, tbl[i].rdat, owt, ort, oresp, odout, olen);
            chk($sformatf("vec%0d_wr_timeout", i), owt, tbl[i].ewto);
            chk($sformatf("vec%0d_rd_timeout", i), ort, tbl[i].erto);
            chk($sformatf("vec%0d_resp", i), oresp, tbl[i].eresp);
            chk($sformatf("vec%0d_dout", i), odout, tbl[i].edout);
            chk($sformatf("vec%0d_len", i), olen, exp_len(tbl[i].is_wr, tbl[i].d1, tbl[i].d2, tbl[i].d3));
        end
        m_dout = 32'hDEADBEEF;

        // Reset asserted mid-cycle while waiting for B.
        new_tx = 1; wr = 1; waddr = 32'h55; din = 32'h66;
        @(posedge clk); #1;
        new_tx = 0; awready = 1; wready = 1;
        @(posedge clk); #1;
        clear_slave();
        chk("in_wr_b_bready", {bready, awvalid, wvalid}, 3'b100);
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("mid_reset_outputs_zero", any_out(), 0);
        @(posedge clk); #1;
        rst = 0;
        m_dout = 0;
        @(posedge clk); #1;
        chk("no_flag_after_reset", {wr_timeout, rd_timeout, resp}, 4'b0000);
        run_model("post_reset_wr", 1, 32'h77, 32'h88, 1, 0, 1, 2'b00, 32'h0);

        for (int i = 0; i < 10; i++)
            run_model("b2b_wr", 1, i, i, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 2'b00, 32'h0);
        for (int i = 0; i < 10; i++)
            run_model("b2b_rd", 0, i, 0, $urandom_range(0, 3), $urandom_range(0, 3), 0, 2'b00, 32'h5);
        chk("b2b_last_dout", dout, 32'h5);

        for (int i = 0; i < 40; i++) begin
            bit is_wr;
            int d1, d2, d3;
            is_wr = 1'($urandom_range(0, 1));
            d1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 19)) : int'($urandom_range(0, 4));
            d2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 19)) : int'($urandom_range(0, 4));
            d3 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 19)) : int'($urandom_range(0, 4));
            run_model("rand", is_wr, $urandom, $urandom, d1, d2, d3, 2'($urandom_range(0, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
